// File: rtl/trap_ctrl_p.sv
// rtl/trap_ctrl_p.sv - pipeline stall vector, trap/mret arbitration, fetch redirect and CSR strobes
module trap_ctrl_p #(
  parameter int XLEN    = 32,
  parameter int N_REQ   = 4,
  parameter int N_IRQ   = 16,
  parameter int CAUSE_W = 5,
  parameter logic [XLEN-1:0] RESET_ADDR = {XLEN{1'b0}}
) (
  input  logic               clk_i,
  input  logic               n_rst_i,
  input  logic [N_REQ-1:0]   stallreq_i,
  input  logic [6:0]         exception_i,
  input  logic [XLEN-1:0]    pc_i,
  input  logic [XLEN-1:0]    ins_i,
  input  logic               mstatus_ie_i,
  input  logic [N_IRQ-1:0]   mie_i,
  input  logic [N_IRQ-1:0]   mip_i,
  input  logic [XLEN-1:0]    mtvec_i,
  input  logic [XLEN-1:0]    epc_i,
  output logic [N_REQ+1:0]   stall_o,
  output logic               flush_o,
  output logic [XLEN-1:0]    new_pc_o,
  output logic               set_cause_o,
  output logic               cause_irq_o,
  output logic [CAUSE_W-1:0] cause_code_o,
  output logic               set_epc_o,
  output logic [XLEN-1:0]    epc_o,
  output logic               set_mtval_o,
  output logic [XLEN-1:0]    mtval_o,
  output logic               mstatus_ie_clear_o,
  output logic               mstatus_ie_set_o
);

  typedef enum logic [3:0] {
    ST_RESET     = 4'b0001,
    ST_OPERATING = 4'b0010,
    ST_TRAP_TAKEN  = 4'b0100,
    ST_TRAP_RETURN = 4'b1000
  } state_e;

  state_e state_q, state_d;

  logic               cause_irq_q;
  logic [CAUSE_W-1:0] cause_code_q;
  logic [XLEN-1:0]    epc_q;
  logic [XLEN-1:0]    mtval_q;
  logic               mtval_flag_q;

  logic [N_IRQ-1:0]   irq_act;
  logic               ip, trap, mret, hold, take;
  logic [CAUSE_W-1:0] irq_code;
  logic               cap_irq;
  logic [CAUSE_W-1:0] cap_code;
  logic [XLEN-1:0]    cap_mtval;
  logic               cap_mtval_flag;
  int                 stall_top;
  logic               stall_any;
  logic [XLEN-1:0]    tvec_base;

  // Highest requesting stage k stalls everything up to k+1, never less than bit 2
  always_comb begin
    stall_o   = '0;
    stall_top = 0;
    stall_any = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (stallreq_i[k]) begin
        stall_top = k + 1;
        stall_any = 1'b1;
      end
    end
    if (stall_top < 2) stall_top = 2;
    if (stall_any && n_rst_i) begin
      for (int j = 0; j < N_REQ + 2; j++) begin
        if (j <= stall_top) stall_o[j] = 1'b1;
      end
    end
  end

  assign irq_act = mie_i & mip_i;
  assign ip      = mstatus_ie_i & (|irq_act);
  assign trap    = ip | (|exception_i[6:1]);
  assign mret    = exception_i[0];
  assign hold    = stallreq_i[N_REQ-1];
  assign take    = (state_q == ST_OPERATING) && trap && !hold;

  // Lines 11, 3, 7 outrank the rest; remaining lines go lowest index first
  always_comb begin
    irq_code = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (irq_act[i] && i != 3 && i != 7 && i != 11) irq_code = CAUSE_W'(i);
    end
    if (irq_act[7])  irq_code = CAUSE_W'(7);
    if (irq_act[3])  irq_code = CAUSE_W'(3);
    if (irq_act[11]) irq_code = CAUSE_W'(11);
  end

  always_comb begin
    cap_irq        = 1'b0;
    cap_code       = '0;
    cap_mtval      = '0;
    cap_mtval_flag = 1'b0;
    if (ip) begin
      cap_irq  = 1'b1;
      cap_code = irq_code;
    end else if (exception_i[3]) begin
      cap_code       = CAUSE_W'(0);
      cap_mtval      = pc_i;
      cap_mtval_flag = 1'b1;
    end else if (exception_i[4]) begin
      cap_code       = CAUSE_W'(2);
      cap_mtval      = ins_i;
      cap_mtval_flag = 1'b1;
    end else if (exception_i[2]) begin
      cap_code       = CAUSE_W'(3);
      cap_mtval      = pc_i;
      cap_mtval_flag = 1'b1;
    end else if (exception_i[5]) begin
      cap_code       = CAUSE_W'(6);
      cap_mtval      = pc_i;
      cap_mtval_flag = 1'b1;
    end else if (exception_i[6]) begin
      cap_code       = CAUSE_W'(4);
      cap_mtval      = pc_i;
      cap_mtval_flag = 1'b1;
    end else begin
      cap_code = CAUSE_W'(11);
    end
  end

  always_comb begin
    state_d = ST_OPERATING;
    case (state_q)
      ST_RESET:       state_d = ST_OPERATING;
      ST_OPERATING: begin
        if (take)              state_d = ST_TRAP_TAKEN;
        else if (mret && !hold) state_d = ST_TRAP_RETURN;
        else                   state_d = ST_OPERATING;
      end
      ST_TRAP_TAKEN:  state_d = ST_OPERATING;
      ST_TRAP_RETURN: state_d = ST_OPERATING;
      default:        state_d = ST_OPERATING;
    endcase
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state_q      <= ST_RESET;
      cause_irq_q  <= 1'b0;
      cause_code_q <= '0;
      epc_q        <= '0;
      mtval_q      <= '0;
      mtval_flag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (take) begin
        cause_irq_q  <= cap_irq;
        cause_code_q <= cap_code;
        epc_q        <= pc_i;
        mtval_q      <= cap_mtval;
        mtval_flag_q <= cap_mtval_flag;
      end
    end
  end

  assign cause_irq_o  = cause_irq_q;
  assign cause_code_o = cause_code_q;
  assign epc_o        = epc_q;
  assign mtval_o      = mtval_q;
  assign tvec_base    = {mtvec_i[XLEN-1:2], 2'b00};

  // Strobes are gated by reset so they drop the instant reset asserts
  always_comb begin
    flush_o            = 1'b0;
    new_pc_o           = '0;
    set_cause_o        = 1'b0;
    set_epc_o          = 1'b0;
    set_mtval_o        = 1'b0;
    mstatus_ie_clear_o = 1'b0;
    mstatus_ie_set_o   = 1'b0;
    if (n_rst_i) begin
      case (state_q)
        ST_RESET: begin
          flush_o  = 1'b1;
          new_pc_o = RESET_ADDR;
        end
        ST_TRAP_TAKEN: begin
          flush_o            = 1'b1;
          set_cause_o        = 1'b1;
          set_epc_o          = 1'b1;
          set_mtval_o        = mtval_flag_q;
          mstatus_ie_clear_o = 1'b1;
          if (mtvec_i[1:0] == 2'b01 && cause_irq_q)
            new_pc_o = tvec_base + (XLEN'(cause_code_q) << 2);
          else
            new_pc_o = tvec_base;
        end
        ST_TRAP_RETURN: begin
          flush_o          = 1'b1;
          new_pc_o         = epc_i;
          mstatus_ie_set_o = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
